serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Parametrised bit-serial adder/subtractor: one full-adder cell reused over W cycles, LSB first.
//  Carry is held in a flip-flop between bits. Start/busy/done handshake to the datapath controller.
//  Adds carry-in, subtract mode, carry-out and signed overflow, which the one-bit cell lacks.
//  Trades latency for area; sits between operand registers and the result bus of lab datapaths.
// PARAMETERS
//  W   8   operand/result width in bits; W >= 1
// PORTS
//  clk       in   1   single clock; all state changes on rising edge
//  rst       in   1   synchronous, active-high reset
//  start     in   1   request; sampled only in IDLE or DONE
//  sub       in   1   0: a+b+cin   1: a-b-cin; captured with start
//  cin       in   1   carry-in (add) / borrow-in (sub); captured with start
//  a         in   W   operand A; captured with start
//  b         in   W   operand B; captured with start
//  busy      out  1   high in RUN
//  done      out  1   one-cycle pulse in DONE; results valid
//  sum       out  W   result; registered, held until next DONE
//  cout      out  1   raw carry out of MSB (sub: 1 = no borrow)
//  overflow  out  1   signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; counter, shift regs, carry FF=0.
//  rst wins over all other inputs; rst mid-RUN discards the operation, no done pulse.
//  States: IDLE -(start)-> RUN -(W bits processed)-> DONE -(start)-> RUN, else -> IDLE.
//  Start edge (cycle 0): load A shift reg=a, B shift reg=(sub ? ~b : b), carry FF=(sub ? ~cin : cin), count=0.
//  RUN, cycles 1..W: bit i=count from LSB of A/B regs through the cell; sum bit shifts into result reg
//   from MSB side; carry FF<=cell carry; A/B shift right; count++.
//  On the edge processing bit W-1: sum<=completed result, cout<=cell carry,
//   overflow<=carry FF (carry into MSB) XOR cell carry; state->DONE.
//  done=1 exactly in cycle W+1 after start acceptance; latency start->done = W+1 cycles.
//  start while busy=1 is ignored (no queueing); operand inputs only matter on accepting edge.
//  start in DONE is accepted: back-to-back operations, throughput one result per W+1 cycles.
//  sum/cout/overflow change only on DONE entry or reset; stable during next RUN.
//  Width rules: modulo 2^W; W=1 legal (RUN one cycle). Counter width $clog2(W+1).
// STRUCTURE
//  serial_adder_pkg: state encodings ST_IDLE/ST_RUN/ST_DONE (2-bit localparams), counter-width function.
//  Sub-module: fa_cell (combinational 1-bit full adder: a,b,ci -> s,co), single instance.
//  Top: FSM, bit counter, A/B shift regs, carry FF, result shift reg, output registers.
// TESTING (W=8 unless stated)
//  a=7F b=01 cin=0 sub=0 -> done at cycle 9, sum=80 cout=0 overflow=1; busy high cycles 1..8.
//  a=FF b=01 cin=0 sub=0 -> sum=00 cout=1 overflow=0; then a=05 b=07 sub=1 cin=0 -> sum=FE cout=0 overflow=0.
//  a=80 b=01 sub=1 cin=0 -> sum=7F cout=1 overflow=1; a=10 b=03 sub=1 cin=1 -> sum=0C cout=1.
//  start held high continuously -> done every 9 cycles; start pulses during RUN ignored, sum unchanged till DONE.
//  rst at cycle 4 of RUN -> next cycle IDLE, all outputs 0, no done; fresh start then completes normally.
//  W=1: a=1 b=1 cin=1 sub=0 -> done at cycle 2, sum=1 cout=1 overflow=0; random 1000-op scoreboard vs a+b+cin.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encodings and
// the width helper for the bit counter.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must reach W after the last bit, so it needs $clog2(W+1) bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder; the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell walks the operands LSB first over W
// cycles, with start/busy/done handshake and registered sum, carry-out and signed overflow.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int unsigned CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q, b_q, res_q, res_shift;
  logic          carry_q;
  logic [W-1:0]  sum_q;
  logic          cout_q, overflow_q;

  logic cell_s, cell_co;
  logic accept, running, last_bit;

  fa_cell u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // Start is only honoured outside RUN; a request while busy is simply dropped.
  assign accept   = start && (state_q != ST_RUN);
  assign running  = (state_q == ST_RUN);
  assign last_bit = running && (cnt_q == LAST_BIT);

  // New sum bit enters from the MSB side so the LSB-first stream lands in place.
  always_comb begin
    res_shift        = res_q >> 1;
    res_shift[W-1]   = cell_s;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last_bit) state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry-in.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? ~cin : cin;
        cnt_q   <= '0;
        res_q   <= '0;
      end else if (running) begin
        a_q     <= a_q >> 1;
        b_q     <= b_q >> 1;
        carry_q <= cell_co;
        res_q   <= res_shift;
        cnt_q   <= cnt_q + 1'b1;
        if (last_bit) begin
          sum_q      <= res_shift;
          cout_q     <= cell_co;
          overflow_q <= carry_q ^ cell_co;
        end
      end
    end
  end

  assign busy     = running;
  assign done     = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at W=8 and W=1 against an arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s8_start, s8_sub, s8_cin;
  logic [7:0] s8_a, s8_b, s8_sum;
  logic       s8_busy, s8_done, s8_cout, s8_ov;

  logic       s1_start, s1_sub, s1_cin;
  logic [0:0] s1_a, s1_b, s1_sum;
  logic       s1_busy, s1_done, s1_cout, s1_ov;

  int tests = 0;
  int fails = 0;

  serial_adder #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .sub(s8_sub), .cin(s8_cin),
    .a(s8_a), .b(s8_b), .busy(s8_busy), .done(s8_done), .sum(s8_sum),
    .cout(s8_cout), .overflow(s8_ov)
  );

  serial_adder #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .sub(s1_sub), .cin(s1_cin),
    .a(s1_a), .b(s1_b), .busy(s1_busy), .done(s1_done), .sum(s1_sum),
    .cout(s1_cout), .overflow(s1_ov)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                input logic cin, input logic sub,
                                output logic [7:0] s, output logic co, output logic ov);
    int m, ua, ub, sa, sb, ci, r, sr;
    m  = 1 << w;
    ua = int'(a) % m;
    ub = int'(b) % m;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    ci = cin ? 1 : 0;
    if (!sub) begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      co = (r >= m);
    end else begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      co = (r >= 0);
    end
    s  = 8'((r + m) % m);
    ov = (sr >= m / 2) || (sr < -(m / 2));
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input string tag);
    logic [7:0] es, prev;
    logic       ec, eo, held;
    int         k, nbusy;
    model(8, a, b, cin, sub, es, ec, eo);
    prev = s8_sum;
    s8_a = a; s8_b = b; s8_cin = cin; s8_sub = sub; s8_start = 1'b1;
    step;
    s8_start = 1'b0;
    s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom); s8_sub = 1'($urandom);
    k = 1; nbusy = 0; held = 1'b1;
    while (!s8_done && k < 20) begin
      if (s8_busy) nbusy++;
      if (s8_sum !== prev) held = 1'b0;
      s8_start = (k == 3);  // stray request mid-RUN must be ignored
      step;
      k++;
    end
    s8_start = 1'b0;
    chk({tag, " latency"}, k, 9);
    chk({tag, " busy_cycles"}, nbusy, 8);
    chk({tag, " sum_held_in_run"}, held, 1'b1);
    chk({tag, " busy_in_done"}, s8_busy, 1'b0);
    chk({tag, " sum"}, s8_sum, es);
    chk({tag, " cout"}, s8_cout, ec);
    chk({tag, " overflow"}, s8_ov, eo);
    step;
    chk({tag, " done_pulse_width"}, s8_done, 1'b0);
  endtask

  task automatic run1(input logic a, input logic b, input logic cin, input logic sub,
                      input string tag);
    logic [7:0] es;
    logic       ec, eo;
    int         k;
    model(1, {7'd0, a}, {7'd0, b}, cin, sub, es, ec, eo);
    s1_a = a; s1_b = b; s1_cin = cin; s1_sub = sub; s1_start = 1'b1;
    step;
    s1_start = 1'b0;
    chk({tag, " busy"}, s1_busy, 1'b1);
    k = 1;
    while (!s1_done && k < 10) begin
      step;
      k++;
    end
    chk({tag, " latency"}, k, 2);
    chk({tag, " sum"}, s1_sum, es[0]);
    chk({tag, " cout"}, s1_cout, ec);
    chk({tag, " overflow"}, s1_ov, eo);
    step;
  endtask

  initial begin
    logic [7:0] ha, hb, es;
    logic       hc, hs, ec, eo, seen;
    int         n;

    rst = 1'b1;
    s8_start = 1'b0; s8_sub = 1'b0; s8_cin = 1'b0; s8_a = '0; s8_b = '0;
    s1_start = 1'b0; s1_sub = 1'b0; s1_cin = 1'b0; s1_a = '0; s1_b = '0;
    step;
    step;
    chk("rst busy", s8_busy, 1'b0);
    chk("rst done", s8_done, 1'b0);
    chk("rst sum", s8_sum, 8'h00);
    chk("rst cout", s8_cout, 1'b0);
    chk("rst overflow", s8_ov, 1'b0);
    chk("rst w1 busy", s1_busy, 1'b0);
    chk("rst w1 sum", s1_sum, 1'b0);
    rst = 1'b0;
    step;

    // Directed vectors with hand-known results.
    run8(8'h7F, 8'h01, 1'b0, 1'b0, "add7F01");
    chk("add7F01 literal sum", s8_sum, 8'h80);
    chk("add7F01 literal ov", s8_ov, 1'b1);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, "addFF01");
    chk("addFF01 literal cout", s8_cout, 1'b1);
    run8(8'h05, 8'h07, 1'b0, 1'b1, "sub0507");
    chk("sub0507 literal sum", s8_sum, 8'hFE);
    run8(8'h80, 8'h01, 1'b0, 1'b1, "sub8001");
    chk("sub8001 literal sum", s8_sum, 8'h7F);
    chk("sub8001 literal ov", s8_ov, 1'b1);
    run8(8'h10, 8'h03, 1'b1, 1'b1, "sub1003b");
    chk("sub1003b literal sum", s8_sum, 8'h0C);

    // Start held high: back-to-back operations, one result every 9 cycles.
    ha = 8'($urandom); hb = 8'($urandom); hc = 1'($urandom); hs = 1'($urandom);
    s8_a = ha; s8_b = hb; s8_cin = hc; s8_sub = hs; s8_start = 1'b1;
    for (int it = 0; it < 4; it++) begin
      model(8, ha, hb, hc, hs, es, ec, eo);
      step;
      n = 1;
      while (!s8_done && n < 20) begin
        s8_a = 8'($urandom); s8_b = 8'($urandom); s8_cin = 1'($urandom); s8_sub = 1'($urandom);
        step;
        n++;
      end
      chk($sformatf("hold%0d period", it), n, 9);
      chk($sformatf("hold%0d sum", it), s8_sum, es);
      chk($sformatf("hold%0d cout", it), s8_cout, ec);
      chk($sformatf("hold%0d overflow", it), s8_ov, eo);
      ha = 8'($urandom); hb = 8'($urandom); hc = 1'($urandom); hs = 1'($urandom);
      s8_a = ha; s8_b = hb; s8_cin = hc; s8_sub = hs;
    end
    s8_start = 1'b0;
    step;
    step;

    // Reset in cycle 4 of RUN discards the operation and clears the outputs.
    run8(8'h7F, 8'h01, 1'b0, 1'b0, "prerst");
    s8_a = 8'h12; s8_b = 8'h34; s8_cin = 1'b0; s8_sub = 1'b0; s8_start = 1'b1;
    step;
    s8_start = 1'b0;
    step;
    step;
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst busy", s8_busy, 1'b0);
    chk("midrst done", s8_done, 1'b0);
    chk("midrst sum", s8_sum, 8'h00);
    chk("midrst cout", s8_cout, 1'b0);
    chk("midrst overflow", s8_ov, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step;
      if (s8_done || s8_busy) seen = 1'b1;
    end
    chk("midrst no_done", seen, 1'b0);
    run8(8'h12, 8'h34, 1'b1, 1'b0, "postrst");

    for (int i = 0; i < 100; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd8_%0d", i));

    run1(1'b1, 1'b1, 1'b1, 1'b0, "w1_111");
    chk("w1_111 literal sum", s1_sum, 1'b1);
    chk("w1_111 literal cout", s1_cout, 1'b1);
    chk("w1_111 literal ov", s1_ov, 1'b0);
    for (int i = 0; i < 1000; i++)
      run1(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd1_%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
